// File: rtl/matrix_bram_responder.sv
// matrix_bram_responder: owner of the matrix storage array.
// Serves the operator port with a fixed 1-cycle read latency, a host port
// through a req/ack handshake, and a sequential clear engine.
// Optional feature macro: MATRIX_MEM_WR_FWD_EN (write-first forwarding for a
// same-cycle op read and op write to the same address; read-first otherwise).
module matrix_bram_responder #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_rd_en,
  input  logic [ADDR_WIDTH-1:0]    op_rd_addr,
  output logic [ELEMENT_WIDTH-1:0] op_rd_data,
  input  logic                     op_wr_en,
  input  logic [ADDR_WIDTH-1:0]    op_wr_addr,
  input  logic [ELEMENT_WIDTH-1:0] op_wr_data,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [ADDR_WIDTH-1:0]    host_addr,
  input  logic [ELEMENT_WIDTH-1:0] host_wdata,
  output logic                     host_ack,
  output logic [ELEMENT_WIDTH-1:0] host_rdata,
  input  logic                     clr_start,
  input  logic [ADDR_WIDTH-1:0]    clr_base,
  input  logic [ADDR_WIDTH-1:0]    clr_len,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOST,
    S_ACK,
    S_CLEAR
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    clrAddr_q, clrAddr_d;
  logic [ADDR_WIDTH-1:0]    clrCnt_q, clrCnt_d;
  logic [ELEMENT_WIDTH-1:0] opRdData_q;
  logic [ELEMENT_WIDTH-1:0] hostRdata_q;

  logic [ELEMENT_WIDTH-1:0] mem [DEPTH];

  logic                     clearing;
  logic                     hostGo;
  logic                     memWe;
  logic [ADDR_WIDTH-1:0]    memWaddr;
  logic [ELEMENT_WIDTH-1:0] memWdata;
  logic [ELEMENT_WIDTH-1:0] opRdWord;

  // The host is only served on a cycle the operator leaves the array alone.
  assign clearing = (state_q == S_CLEAR);
  assign hostGo   = (state_q == S_HOST) && !op_rd_en && !op_wr_en;

  // Next-state logic: clear has priority over host when both arrive in idle.
  always_comb begin
    state_d   = state_q;
    clrAddr_d = clrAddr_q;
    clrCnt_d  = clrCnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr_start && (clr_len != '0)) begin
          state_d   = S_CLEAR;
          clrAddr_d = clr_base;
          clrCnt_d  = clr_len;
        end else if (host_req) begin
          state_d = S_HOST;
        end
      end
      S_HOST: begin
        if (hostGo) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        clrAddr_d = clrAddr_q + 1'b1;
        clrCnt_d  = clrCnt_q - 1'b1;
        if (clrCnt_q == ADDR_WIDTH'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Single write port shared by clear engine, operator and host, in that priority.
  always_comb begin
    memWe    = 1'b0;
    memWaddr = '0;
    memWdata = '0;
    if (clearing) begin
      memWe    = 1'b1;
      memWaddr = clrAddr_q;
    end else if (op_wr_en) begin
      memWe    = 1'b1;
      memWaddr = op_wr_addr;
      memWdata = op_wr_data;
    end else if (hostGo && host_we) begin
      memWe    = 1'b1;
      memWaddr = host_addr;
      memWdata = host_wdata;
    end
  end

  // Operator read word; the clear engine masks reads to zero while it runs.
  always_comb begin
    opRdWord = mem[op_rd_addr];
`ifdef MATRIX_MEM_WR_FWD_EN
    if (op_wr_en && (op_wr_addr == op_rd_addr)) begin
      opRdWord = op_wr_data;
    end
`endif
    if (clearing) begin
      opRdWord = '0;
    end
  end

  // Control state and read-data registers; a reset aborts any clear or host access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clrAddr_q   <= '0;
      clrCnt_q    <= '0;
      opRdData_q  <= '0;
      hostRdata_q <= '0;
    end else begin
      state_q   <= state_d;
      clrAddr_q <= clrAddr_d;
      clrCnt_q  <= clrCnt_d;
      if (op_rd_en) begin
        opRdData_q <= opRdWord;
      end
      if (hostGo && !host_we) begin
        hostRdata_q <= mem[host_addr];
      end
    end
  end

  // Storage array, deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  assign op_rd_data = opRdData_q;
  assign host_ack   = (state_q == S_ACK);
  assign host_rdata = hostRdata_q;
  assign busy       = clearing;

endmodule
